add_order_encoder: RTL and testbench
====================================

# add_order_encoder

Transmit-side counterpart of the Add Order decoder. It accepts one Add Order's fields through a valid/ready handshake and serializes them, most significant byte first, into a 26-byte ITCH 'A' message on a byte stream with backpressure. It sits in the bench/stimulus path and in loopback builds ahead of the payload parser. It frames the message exactly as the decoder unpacks it from `payload[511:304]`.

## Interface
- `GAP_CYCLES`, default 0: number of idle cycles inserted after each message's last byte before `in_ready` reasserts.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: field set valid.
- `in_ready` out 1: encoder can accept a field set.
- `order_ref` in 64: order reference number.
- `buy_sell` in 1: side; 1 = Buy, 0 = Sell.
- `shares` in 32: share quantity.
- `stock_symbol` in 64: 8 ASCII characters.
- `price` in 32: price.
- `out_valid` out 1: `out_byte` valid.
- `out_ready` in 1: downstream accepts a byte.
- `out_byte` out 8: stream byte.
- `out_first` out 1: marks byte 0 (`'A'`).
- `out_last` out 1: marks byte 25.
- `busy` out 1: state is not IDLE.
- `msg_count` out 16: count of completed messages; wraps.

## Operation
- Byte map:
  - byte 0: `8'h41` (`'A'`).
  - bytes 1–8: `order_ref[63:0]`.
  - byte 9: `8'h42` (`'B'`) when `buy_sell` = 1, `8'h53` (`'S'`) when 0.
  - bytes 10–13: `shares`.
  - bytes 14–21: `stock_symbol`.
  - bytes 22–25: `price`.
  - All multi-byte fields are sent MSB first.
- Datapath:
  - 208-bit shift register `shreg`; `out_byte = shreg[207:200]`.
  - 5-bit `byte_idx`, range 0–25.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid & in_ready`, load `shreg` with the full message and clear `byte_idx`, then go to SEND.
- SEND:
  - `out_valid` = 1.
  - On `out_valid & out_ready`, shift `shreg` left by 8 and increment `byte_idx`.
  - When the handshake occurs at `byte_idx` == 25, increment `msg_count` and go to GAP if `GAP_CYCLES` > 0, otherwise to IDLE.
- GAP:
  - Counts `GAP_CYCLES` cycles with `out_valid` = 0, then goes to IDLE.
- Flags:
  - `out_first` = SEND & (`byte_idx` == 0).
  - `out_last` = SEND & (`byte_idx` == 25).
- Stall: while `out_valid` & !`out_ready`, `out_byte`, `out_first` and `out_last` hold stable. `out_valid` never drops mid-message.
- `in_ready` is low in SEND and GAP. Input fields are sampled only at the accept edge; later changes have no effect on the message in flight.
- `msg_count` wraps from 16'hFFFF to 0.

## Timing
- Reset state, applied asynchronously on `rst_n` low:
  - state IDLE; `in_ready` = 1.
  - `out_valid`, `out_first`, `out_last`, `busy` = 0.
  - `out_byte` = 0; `msg_count` = 0; `shreg` = 0; `byte_idx` = 0.
- Reset mid-message aborts the message. No partial tail is emitted after release, and `msg_count` is not incremented.
- Latency: a field set accepted at edge N gives `out_valid` = 1 with byte 0 from cycle N+1.
- Throughput with `out_ready` held high and `GAP_CYCLES` = 0:
  - 26 byte cycles plus one IDLE cycle = 27 cycles per message.
  - `in_ready` reasserts the cycle after the edge that accepts the last byte.
- `out_ready` is allowed to toggle every cycle. Exactly one byte advances per handshake edge.
- All outputs are registered or decoded only from registered state. There is no combinational path from `out_ready` or `in_valid` to any output.

## Structure
- Shared package `itch_pkg`, also used by the decoders:
  - `ITCH_MSG_ADD` = `8'h41`; `ITCH_SIDE_BUY` = `8'h42`; `ITCH_SIDE_SELL` = `8'h53`.
  - `ADD_ORDER_LEN` = 26.
  - Field byte offsets: `OFS_REF` = 1, `OFS_SIDE` = 9, `OFS_SHARES` = 10, `OFS_SYM` = 14, `OFS_PRICE` = 22.
  - FSM state enum.
- No sub-module. The shift register, `byte_idx` and gap counter stay in one module.

## Test plan
- Basic send, `out_ready` = 1, `GAP_CYCLES` = 0:
  - Stimulus: `order_ref` = 64'h0000_0000_0000_1234, `buy_sell` = 1, `shares` = 100, `stock_symbol` = "AAPL    ", `price` = 32'h0001_86A0.
  - Required: 26 consecutive bytes `41 00 00 00 00 00 00 12 34 42 00 00 00 64 41 41 50 4C 20 20 20 20 00 01 86 A0`.
  - Required: `out_first` on byte 0, `out_last` on byte 25, `msg_count` = 1.
- Sell side, `buy_sell` = 0 -> byte 9 = 8'h53. Loopback of the 26 bytes into `payload[511:304]` of the decoder -> `add_order_decoded` = 1 with identical fields.
- Backpressure: `out_ready` pattern 1,0,0,1 repeating -> `out_byte` stable during stalls, no byte dropped or duplicated, 26 handshakes total.
- Back-to-back:
  - `in_valid` held high with two field sets and `GAP_CYCLES` = 0 -> second message's `out_first` appears exactly 27 cycles after the first's.
  - With `GAP_CYCLES` = 3 -> 30 cycles.
  - Changing the inputs during SEND does not alter the bytes in flight.
- Reset mid-message: `rst_n` low after byte 10 -> `out_valid` = 0 immediately, `msg_count` = 0. After release, `in_ready` = 1 and a new message starts cleanly with 8'h41.
- Counter wrap: preload via 65,536 short-circuited sends (or a force) -> `msg_count` goes 16'hFFFF -> 0.

Source files
------------

// File: rtl/itch_pkg.sv
// ITCH message constants shared by the Add Order encoder and decoders.
// Also provides the 208-bit Add Order framing helper.
package itch_pkg;

  localparam logic [7:0] ITCH_MSG_ADD   = 8'h41;
  localparam logic [7:0] ITCH_SIDE_BUY  = 8'h42;
  localparam logic [7:0] ITCH_SIDE_SELL = 8'h53;

  localparam int ADD_ORDER_LEN = 26;

  localparam int OFS_REF    = 1;
  localparam int OFS_SIDE   = 9;
  localparam int OFS_SHARES = 10;
  localparam int OFS_SYM    = 14;
  localparam int OFS_PRICE  = 22;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP
  } enc_state_e;

  // Same layout the decoder unpacks from payload[511:304].
  function automatic logic [207:0] pack_add(
    input logic [63:0] order_ref,
    input logic        buy_sell,
    input logic [31:0] shares,
    input logic [63:0] stock_symbol,
    input logic [31:0] price
  );
    logic [7:0] side;
    side = buy_sell ? ITCH_SIDE_BUY
                    : ITCH_SIDE_SELL;
    return {ITCH_MSG_ADD, order_ref, side,
            shares, stock_symbol, price};
  endfunction

endpackage

// File: rtl/add_order_encoder.sv
// Serializes one Add Order field set into a 26-byte ITCH 'A' message,
// MSB first, on a valid/ready byte stream with an optional idle gap.
module add_order_encoder
  import itch_pkg::*;
#(
  parameter int GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] order_ref,
  input  logic        buy_sell,
  input  logic [31:0] shares,
  input  logic [63:0] stock_symbol,
  input  logic [31:0] price,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_first,
  output logic        out_last,
  output logic        busy,
  output logic [15:0] msg_count
);

  localparam logic [4:0] LAST_IDX =
    5'(ADD_ORDER_LEN - 1);
  localparam logic [15:0] GAP_END =
    16'(GAP_CYCLES - 1);

  enc_state_e   state_q, state_d;
  logic [207:0] shreg_q;
  logic [4:0]   idx_q;
  logic [15:0]  gap_q;
  logic [15:0]  cnt_q;

  logic accept;
  logic send_hs;
  logic at_last;

  assign at_last = (idx_q == LAST_IDX);
  assign accept  = (state_q == ST_IDLE)
                 & in_valid;
  assign send_hs = (state_q == ST_SEND)
                 & out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (in_valid) state_d = ST_SEND;
      ST_SEND:
        if (out_ready && at_last)
          state_d = (GAP_CYCLES > 0)
                  ? ST_GAP : ST_IDLE;
      ST_GAP:
        if (gap_q == GAP_END)
          state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
    end else if (accept) begin
      shreg_q <= pack_add(order_ref, buy_sell,
                          shares, stock_symbol,
                          price);
      idx_q   <= '0;
    end else if (send_hs) begin
      shreg_q <= {shreg_q[199:0], 8'h00};
      idx_q   <= at_last ? 5'd0 : idx_q + 5'd1;
      gap_q   <= '0;
    end else if (state_q == ST_GAP) begin
      gap_q   <= gap_q + 16'd1;
    end
  end

  // Kept apart so the count only moves on a completed message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (send_hs && at_last) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_SEND);
  assign busy      = (state_q != ST_IDLE);
  assign out_byte  = shreg_q[207:200];
  assign out_first = out_valid & (idx_q == 5'd0);
  assign out_last  = out_valid & at_last;
  assign msg_count = cnt_q;

endmodule

// File: tb/tb_add_order_encoder.sv
// Directed bench for add_order_encoder with a zero-gap and a
// three-cycle-gap instance driven from the same stimulus.
module tb_add_order_encoder;

  localparam logic [207:0] EXP1 =
    208'h41_0000000000001234_42_00000064_4141504C20202020_000186A0;
  localparam logic [207:0] EXP2 =
    208'h41_DEADBEEF01234567_53_000003E8_4D53465420202020_0012D687;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] order_ref = '0;
  logic        buy_sell = 1'b0;
  logic [31:0] shares = '0;
  logic [63:0] stock_symbol = '0;
  logic [31:0] price = '0;
  logic        out_ready = 1'b1;

  logic        in_ready0, out_valid0, out_first0;
  logic        out_last0, busy0;
  logic [7:0]  out_byte0;
  logic [15:0] msg_count0;
  logic        in_ready3, out_valid3, out_first3;
  logic        out_last3, busy3;
  logic [7:0]  out_byte3;
  logic [15:0] msg_count3;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  add_order_encoder #(.GAP_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready0),
    .order_ref(order_ref), .buy_sell(buy_sell),
    .shares(shares), .stock_symbol(stock_symbol),
    .price(price), .out_valid(out_valid0),
    .out_ready(out_ready), .out_byte(out_byte0),
    .out_first(out_first0), .out_last(out_last0),
    .busy(busy0), .msg_count(msg_count0)
  );

  add_order_encoder #(.GAP_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready3),
    .order_ref(order_ref), .buy_sell(buy_sell),
    .shares(shares), .stock_symbol(stock_symbol),
    .price(price), .out_valid(out_valid3),
    .out_ready(out_ready), .out_byte(out_byte3),
    .out_first(out_first3), .out_last(out_last3),
    .busy(busy3), .msg_count(msg_count3)
  );

  task automatic fields_a();
    order_ref    = 64'h0000_0000_0000_1234;
    buy_sell     = 1'b1;
    shares       = 32'd100;
    stock_symbol = "AAPL    ";
    price        = 32'h0001_86A0;
  endtask

  task automatic fields_b();
    order_ref    = 64'hDEAD_BEEF_0123_4567;
    buy_sell     = 1'b0;
    shares       = 32'h0000_03E8;
    stock_symbol = "MSFT    ";
    price        = 32'h0012_D687;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Present fields for one edge; returns at the negedge after accept.
  task automatic send(input bit sel_b);
    if (sel_b) fields_b();
    else fields_a();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Gathers n handshaked bytes of u0; called at a negedge.
  task automatic collect(input int n,
                         input logic [3:0] pat,
                         output logic [207:0] cap,
                         output int nhs,
                         output int bad);
    int c;
    logic stall;
    logic [7:0] pb;
    logic pf, pl;
    cap = '0; nhs = 0; bad = 0;
    c = 0; stall = 1'b0;
    pb = '0; pf = 1'b0; pl = 1'b0;
    while (nhs < n && c < 400) begin
      if (stall && (out_byte0 !== pb ||
          out_first0 !== pf || out_last0 !== pl ||
          out_valid0 !== 1'b1))
        bad++;
      out_ready = pat[c % 4];
      c++;
      if (out_valid0 && out_ready) begin
        cap = {cap[199:0], out_byte0};
        if (out_first0 !== (nhs == 0)) bad++;
        if (out_last0 !== (nhs == 25)) bad++;
        nhs++;
        stall = 1'b0;
      end else begin
        stall = out_valid0;
        pb = out_byte0;
        pf = out_first0;
        pl = out_last0;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total++;
    if (in_ready0 !== 1'b1)
      $display("FAIL reset_in_ready got %b want 1", in_ready0);
    else passed++;
    total++;
    if ({out_valid0, out_first0, out_last0, busy0} !== 4'b0)
      $display("FAIL reset_flags got %b want 0000",
               {out_valid0, out_first0, out_last0, busy0});
    else passed++;
    total++;
    if (out_byte0 !== 8'h00)
      $display("FAIL reset_out_byte got %h want 00", out_byte0);
    else passed++;
    total++;
    if (msg_count0 !== 16'h0)
      $display("FAIL reset_msg_count got %h want 0000", msg_count0);
    else passed++;
    do_reset();
  endtask

  task automatic test_basic();
    logic [207:0] cap;
    int nhs, bad;
    do_reset();
    send(1'b0);
    total++;
    if (out_valid0 !== 1'b1 || out_first0 !== 1'b1 ||
        out_byte0 !== 8'h41)
      $display("FAIL basic_latency got v=%b f=%b b=%h want 1 1 41",
               out_valid0, out_first0, out_byte0);
    else passed++;
    collect(26, 4'b1111, cap, nhs, bad);
    total++;
    if (nhs !== 26)
      $display("FAIL basic_handshakes got %0d want 26", nhs);
    else passed++;
    total++;
    if (cap !== EXP1)
      $display("FAIL basic_bytes got %h want %h", cap, EXP1);
    else passed++;
    total++;
    if (bad !== 0)
      $display("FAIL basic_flags got %0d errors want 0", bad);
    else passed++;
    total++;
    if (in_ready0 !== 1'b1 || busy0 !== 1'b0)
      $display("FAIL basic_in_ready got r=%b b=%b want 1 0",
               in_ready0, busy0);
    else passed++;
    total++;
    if (msg_count0 !== 16'd1)
      $display("FAIL basic_msg_count got %0d want 1", msg_count0);
    else passed++;
    total++;
    if (in_ready3 !== 1'b0 || busy3 !== 1'b1 ||
        out_valid3 !== 1'b0)
      $display("FAIL gap_state got r=%b b=%b v=%b want 0 1 0",
               in_ready3, busy3, out_valid3);
    else passed++;
  endtask

  task automatic test_sell();
    logic [207:0] cap;
    int nhs, bad;
    do_reset();
    send(1'b1);
    collect(26, 4'b1111, cap, nhs, bad);
    total++;
    if (cap !== EXP2)
      $display("FAIL sell_bytes got %h want %h", cap, EXP2);
    else passed++;
    total++;
    if (cap[135:128] !== 8'h53)
      $display("FAIL sell_side got %h want 53", cap[135:128]);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [207:0] cap;
    int nhs, bad;
    do_reset();
    send(1'b0);
    collect(26, 4'b1001, cap, nhs, bad);
    total++;
    if (nhs !== 26)
      $display("FAIL bp_handshakes got %0d want 26", nhs);
    else passed++;
    total++;
    if (cap !== EXP1)
      $display("FAIL bp_bytes got %h want %h", cap, EXP1);
    else passed++;
    total++;
    if (bad !== 0)
      $display("FAIL bp_stall_stable got %0d errors want 0", bad);
    else passed++;
    total++;
    if (msg_count0 !== 16'd1 || out_valid0 !== 1'b0)
      $display("FAIL bp_done got cnt=%0d v=%b want 1 0",
               msg_count0, out_valid0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [207:0] ma, mb;
    int m, t0a, t0b, t3a, t3b, n3;
    do_reset();
    ma = '0; mb = '0; m = 0; n3 = 0;
    t0a = -1; t0b = -1; t3a = -1; t3b = -1;
    fields_a();
    in_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (out_valid0 && out_first0) begin
        m++;
        if (m == 1) t0a = c;
        if (m == 2) t0b = c;
      end
      if (out_valid3 && out_first3) begin
        n3++;
        if (n3 == 1) t3a = c;
        if (n3 == 2) t3b = c;
      end
      if (out_valid0 && m == 1) ma = {ma[199:0], out_byte0};
      if (out_valid0 && m == 2) mb = {mb[199:0], out_byte0};
      if (c == 0) fields_b();
    end
    in_valid = 1'b0;
    total++;
    if (t0b - t0a !== 27 || t0a < 0)
      $display("FAIL b2b_gap0_period got %0d want 27", t0b - t0a);
    else passed++;
    total++;
    if (t3b - t3a !== 30 || t3a < 0)
      $display("FAIL b2b_gap3_period got %0d want 30", t3b - t3a);
    else passed++;
    total++;
    if (ma !== EXP1)
      $display("FAIL b2b_msg1 got %h want %h", ma, EXP1);
    else passed++;
    total++;
    if (mb !== EXP2)
      $display("FAIL b2b_msg2 got %h want %h", mb, EXP2);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [207:0] cap;
    int nhs, bad;
    do_reset();
    send(1'b0);
    collect(11, 4'b1111, cap, nhs, bad);
    total++;
    if (nhs !== 11 || cap[87:0] !== 88'h41_0000000000001234_42_00)
      $display("FAIL mid_prefix got n=%0d %h", nhs, cap[87:0]);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid0 !== 1'b0 || busy0 !== 1'b0 ||
        msg_count0 !== 16'd0)
      $display("FAIL mid_abort got v=%b b=%b cnt=%0d want 0 0 0",
               out_valid0, busy0, msg_count0);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0)
      $display("FAIL mid_release got r=%b v=%b want 1 0",
               in_ready0, out_valid0);
    else passed++;
    send(1'b1);
    total++;
    if (out_byte0 !== 8'h41 || out_first0 !== 1'b1)
      $display("FAIL mid_restart got b=%h f=%b want 41 1",
               out_byte0, out_first0);
    else passed++;
    collect(26, 4'b1111, cap, nhs, bad);
    total++;
    if (cap !== EXP2 || msg_count0 !== 16'd1)
      $display("FAIL mid_resend got %h cnt=%0d", cap, msg_count0);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [207:0] cap;
    int nhs, bad;
    do_reset();
    force u0.cnt_q = 16'hFFFF;
    @(negedge clk);
    release u0.cnt_q;
    @(negedge clk);
    total++;
    if (msg_count0 !== 16'hFFFF)
      $display("FAIL wrap_preload got %h want ffff", msg_count0);
    else passed++;
    send(1'b0);
    collect(26, 4'b1111, cap, nhs, bad);
    total++;
    if (msg_count0 !== 16'h0000)
      $display("FAIL wrap_count got %h want 0000", msg_count0);
    else passed++;
    total++;
    if (cap !== EXP1)
      $display("FAIL wrap_bytes got %h want %h", cap, EXP1);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sell();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
